// File: rtl/proc_io_pkg.sv
// Shared constants for the processor I/O bridge: register map addresses,
// status word bit positions and control word bit positions.
package proc_io_pkg;

  // Read map (processor input addresses)
  localparam int IO_DATA = 0;
  localparam int IO_STAT = 1;

  // Write map (processor output addresses)
  localparam int IO_CTRL = 1;

  // Status word bit positions
  localparam int STAT_IN_EMPTY  = 8;
  localparam int STAT_OUT_FULL  = 9;
  localparam int STAT_UNDERFLOW = 10;
  localparam int STAT_OVERFLOW  = 11;

  // Control word bit positions
  localparam int CTRL_IEN     = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_THR_LSB = 2;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a
// clear strobe that empties it regardless of push/pop in the same cycle.
module io_sync_fifo #(
  parameter int NBDATA = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [NBDATA-1:0]        din,
  input  logic                     pop,
  output logic [NBDATA-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);

  logic [NBDATA-1:0]   r_mem [DEPTH];
  logic [PTRW-1:0]     r_wrPtr;
  logic [PTRW-1:0]     r_rdPtr;
  logic [PTRW:0]       r_count;
  logic                w_doPush;
  logic                w_doPop;

  assign full     = (r_count == (PTRW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;
  assign dout     = empty ? '0 : r_mem[r_rdPtr];

  // Storage array; stale entries are harmless because pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // Pointer and occupancy tracking; reset and clear both empty the FIFO
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_io_bridge.sv
// Peripheral-side responder for the processor I/O port: serves reads from an
// ingress stream FIFO, queues writes into an egress stream FIFO, keeps
// underflow/overflow sticky flags and raises itr from the ingress fill level.
module proc_io_bridge
  import proc_io_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 8,
  parameter int FCNTW  = $clog2(FDEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in,
  input  logic [$clog2(NUIOIN)-1:0] addr_in,
  output logic [NUBITS-1:0]         io_in,
  input  logic                      out_en,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic [NUBITS-1:0]         io_out,
  output logic                      itr,
  input  logic [NUBITS-1:0]         s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [NUBITS-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);

  logic              r_underflow;
  logic              r_overflow;
  logic              r_ien;
  logic [FCNTW-1:0]  r_thresh;
  logic              r_itr;

  logic              w_rdData;
  logic              w_rdStat;
  logic              w_wrData;
  logic              w_wrCtrl;
  logic              w_clr;
  logic              w_underEvt;
  logic              w_overEvt;
  logic [NUBITS-1:0] w_inHead;
  logic              w_inFull;
  logic              w_inEmpty;
  logic [FCNTW-1:0]  w_inCount;
  logic              w_outFull;
  logic              w_outEmpty;
  logic [FCNTW-1:0]  w_outCount;
  logic [NUBITS-1:0] w_status;

  assign w_rdData   = req_in && (addr_in == AIW'(IO_DATA));
  assign w_rdStat   = req_in && (addr_in == AIW'(IO_STAT));
  assign w_wrData   = out_en && (addr_out == AOW'(IO_DATA));
  assign w_wrCtrl   = out_en && (addr_out == AOW'(IO_CTRL));
  assign w_clr      = w_wrCtrl && io_out[CTRL_CLR];
  assign w_underEvt = w_rdData && w_inEmpty && !w_clr;
  assign w_overEvt  = w_wrData && w_outFull && !w_clr;

  assign s_ready = !w_inFull;
  assign m_valid = !w_outEmpty;
  assign itr     = r_itr;

  io_sync_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_inFifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .push  (s_valid && s_ready),
    .din   (s_data),
    .pop   (w_rdData),
    .dout  (w_inHead),
    .full  (w_inFull),
    .empty (w_inEmpty),
    .count (w_inCount)
  );

  io_sync_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_outFifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .push  (w_wrData),
    .din   (io_out),
    .pop   (m_valid && m_ready),
    .dout  (m_data),
    .full  (w_outFull),
    .empty (w_outEmpty),
    .count (w_outCount)
  );

  // Sticky error flags: a new event beats a status-read clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_underEvt) begin
        r_underflow <= 1'b1;
      end else if (w_rdStat) begin
        r_underflow <= 1'b0;
      end
      if (w_overEvt) begin
        r_overflow <= 1'b1;
      end else if (w_rdStat) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Control register; the clear bit acts as a strobe and is not stored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ien    <= 1'b0;
      r_thresh <= '0;
    end else if (w_wrCtrl) begin
      r_ien    <= io_out[CTRL_IEN];
      r_thresh <= io_out[CTRL_THR_LSB +: FCNTW];
    end
  end

  // Level interrupt from the ingress fill level against the programmed threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_itr <= 1'b0;
    end else begin
      r_itr <= r_ien && (w_inCount != '0) && (w_inCount >= r_thresh);
    end
  end

  // Status word assembly; the egress count is not exposed, only its full flag
  always_comb begin
    w_status                 = '0;
    w_status[FCNTW-1:0]      = w_inCount;
    w_status[STAT_IN_EMPTY]  = w_inEmpty;
    w_status[STAT_OUT_FULL]  = w_outFull && (w_outCount != '0);
    w_status[STAT_UNDERFLOW] = r_underflow;
    w_status[STAT_OVERFLOW]  = r_overflow;
  end

  // Zero-latency read mux so the processor samples data in the req_in cycle
  always_comb begin
    io_in = '0;
    if (addr_in == AIW'(IO_DATA)) begin
      io_in = w_inHead;
    end else if (addr_in == AIW'(IO_STAT)) begin
      io_in = w_status;
    end
  end

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed self-checking bench for proc_io_bridge with hand-computed expectations.
module tb_proc_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in;
  logic [0:0]  addr_in;
  logic [15:0] io_in;
  logic        out_en;
  logic [0:0]  addr_out;
  logic [15:0] io_out;
  logic        itr;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;

  int total = 0;
  int bad   = 0;

  proc_io_bridge #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2), .FDEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .addr_in  (addr_in),
    .io_in    (io_in),
    .out_en   (out_en),
    .addr_out (addr_out),
    .io_out   (io_out),
    .itr      (itr),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge so outputs are sampled well away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic procRead(input logic [0:0] a, output logic [15:0] d);
    req_in  = 1'b1;
    addr_in = a;
    #1;
    d = io_in;
    tick();
    req_in = 1'b0;
  endtask

  task automatic procWrite(input logic [0:0] a, input logic [15:0] v);
    out_en   = 1'b1;
    addr_out = a;
    io_out   = v;
    tick();
    out_en = 1'b0;
  endtask

  task automatic streamPush(input logic [15:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    addr_in = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_ready got=%b exp=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_m_data got=%h exp=0000", m_data); end
    total++; if (itr !== 1'b0) begin bad++; $display("[TB] FAIL reset_itr got=%b exp=0", itr); end
    total++; if (io_in !== 16'h0100) begin bad++; $display("[TB] FAIL reset_status got=%h exp=0100", io_in); end
  endtask

  task automatic test_ingress_order();
    logic [15:0] d;
    logic [15:0] exp [3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
    for (int i = 0; i < 3; i++) streamPush(exp[i]);
    procRead(1'b1, d);
    total++; if (d !== 16'h0003) begin bad++; $display("[TB] FAIL ingress_count got=%h exp=0003", d); end
    for (int i = 0; i < 3; i++) begin
      procRead(1'b0, d);
      total++; if (d !== exp[i]) begin bad++; $display("[TB] FAIL ingress_word%0d got=%h exp=%h", i, d, exp[i]); end
    end
    procRead(1'b1, d);
    total++; if (d !== 16'h0100) begin bad++; $display("[TB] FAIL ingress_drained got=%h exp=0100", d); end
  endtask

  task automatic test_underflow();
    logic [15:0] d;
    procRead(1'b0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("[TB] FAIL underflow_data got=%h exp=0000", d); end
    procRead(1'b1, d);
    total++; if (d !== 16'h0500) begin bad++; $display("[TB] FAIL underflow_sticky got=%h exp=0500", d); end
    procRead(1'b1, d);
    total++; if (d !== 16'h0100) begin bad++; $display("[TB] FAIL underflow_cleared got=%h exp=0100", d); end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) procWrite(1'b0, 16'(i));
    procRead(1'b1, d);
    total++; if (d !== 16'h0B00) begin bad++; $display("[TB] FAIL overflow_status got=%h exp=0B00", d); end
    total++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin bad++; $display("[TB] FAIL egress_hold got=%b/%h exp=1/0001", m_valid, m_data); end
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (m_valid !== 1'b1 || m_data !== 16'(i)) begin bad++; $display("[TB] FAIL egress_word%0d got=%b/%h exp=1/%h", i, m_valid, m_data, 16'(i)); end
      tick();
    end
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL egress_drained got=%b exp=0 data=%h", m_valid, m_data); end
    m_ready = 1'b0;
    procRead(1'b1, d);
    total++; if (d !== 16'h0100) begin bad++; $display("[TB] FAIL overflow_cleared got=%h exp=0100", d); end
  endtask

  task automatic test_interrupt();
    logic [15:0] d;
    procWrite(1'b1, 16'h000D);
    streamPush(16'h0101);
    streamPush(16'h0102);
    total++; if (itr !== 1'b0) begin bad++; $display("[TB] FAIL itr_below got=%b exp=0", itr); end
    streamPush(16'h0103);
    total++; if (itr !== 1'b0) begin bad++; $display("[TB] FAIL itr_early got=%b exp=0", itr); end
    tick();
    total++; if (itr !== 1'b1) begin bad++; $display("[TB] FAIL itr_rise got=%b exp=1", itr); end
    procRead(1'b0, d);
    total++; if (d !== 16'h0101) begin bad++; $display("[TB] FAIL itr_pop_data got=%h exp=0101", d); end
    total++; if (itr !== 1'b1) begin bad++; $display("[TB] FAIL itr_hold got=%b exp=1", itr); end
    tick();
    total++; if (itr !== 1'b0) begin bad++; $display("[TB] FAIL itr_fall got=%b exp=0", itr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    procWrite(1'b1, 16'h0002);
    streamPush(16'hAAAA);
    s_valid = 1'b1; s_data = 16'hBBBB; req_in = 1'b1; addr_in = 1'b0;
    #1;
    total++; if (io_in !== 16'hAAAA) begin bad++; $display("[TB] FAIL b2b_head got=%h exp=AAAA", io_in); end
    tick();
    s_valid = 1'b0; req_in = 1'b0;
    procRead(1'b1, d);
    total++; if (d !== 16'h0001) begin bad++; $display("[TB] FAIL b2b_count got=%h exp=0001", d); end
    addr_in = 1'b0;
    #1;
    total++; if (io_in !== 16'hBBBB) begin bad++; $display("[TB] FAIL b2b_new_head got=%h exp=BBBB", io_in); end
    procWrite(1'b0, 16'h1234);
    total++; if (m_valid !== 1'b1 || m_data !== 16'h1234) begin bad++; $display("[TB] FAIL b2b_egress got=%b/%h exp=1/1234", m_valid, m_data); end
    out_en = 1'b1; addr_out = 1'b1; io_out = 16'h0002; s_valid = 1'b1; s_data = 16'hCCCC;
    tick();
    out_en = 1'b0; s_valid = 1'b0;
    total++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("[TB] FAIL clear_flags got=%b/%b exp=1/0", s_ready, m_valid); end
    procRead(1'b1, d);
    total++; if (d !== 16'h0100) begin bad++; $display("[TB] FAIL clear_status got=%h exp=0100", d); end
  endtask

  task automatic test_mid_reset();
    procWrite(1'b1, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      streamPush(16'h4000 + 16'(i));
      procWrite(1'b0, 16'h5000 + 16'(i));
    end
    addr_in = 1'b1;
    #1;
    total++; if (itr !== 1'b1 || m_valid !== 1'b1 || io_in !== 16'h0004) begin bad++; $display("[TB] FAIL prereset got=%b/%b/%h exp=1/1/0004", itr, m_valid, io_in); end
    rst = 1'b1; s_valid = 1'b1; s_data = 16'hDDDD;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || itr !== 1'b0) begin bad++; $display("[TB] FAIL midreset_flags got=%b/%b/%b exp=0/1/0", m_valid, s_ready, itr); end
    total++; if (io_in !== 16'h0100) begin bad++; $display("[TB] FAIL midreset_status got=%h exp=0100", io_in); end
    streamPush(16'h5555);
    tick();
    total++; if (itr !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ien got=%b exp=0", itr); end
  endtask

  initial begin
    rst = 1'b1; req_in = 1'b0; addr_in = 1'b0; out_en = 1'b0; addr_out = 1'b0;
    io_out = 16'h0; s_data = 16'h0; s_valid = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_ingress_order();
    test_underflow();
    test_overflow();
    test_interrupt();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
